// File: rtl/sram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_pkg
// Purpose  : Shared index widths, response record and default address map
//            for the multi-master SRAM bus mux.
// Revision : 1.0 - initial release
// ============================================================================
package sram_bus_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_SLAVES  = 16;
    localparam int MIDX_W      = $clog2(MAX_MASTERS);
    localparam int SIDX_W      = $clog2(MAX_SLAVES);

    localparam logic [4*64-1:0] DEF_SLAVE_BASE =
        {64'h80000000, 64'h60000000, 64'h10000000, 64'h0};
    localparam logic [4*64-1:0] DEF_SLAVE_MASK =
        {~64'hFFFF, ~64'h7, ~64'hFFF, ~64'hFFFF};
    localparam logic [63:0] DEF_ERR_DATA = 64'hDEADBEEF_DEADBEEF;

    typedef struct packed {
        logic              valid;
        logic [MIDX_W-1:0] midx;
        logic [SIDX_W-1:0] sidx;
        logic              unmapped;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter with a registered priority
//            pointer; one grant per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;

    // Search starts at the pointer and wraps; the first requester wins.
    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[(int'(ptr_q) + i) % N]) begin
                found     = 1'b1;
                gnt_idx_o = IDX_W'((int'(ptr_q) + i) % N);
            end
        end
        if (found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
        ptr_d = IDX_W'((int'(gnt_idx_o) + 1) % N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_mux
// Purpose  : Round-robin shared SRAM bus with base/mask slave decode, tagged
//            one-cycle response path and unmapped-access reporting.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_mux
    import sram_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int LEN_ADDR    = 64,
    parameter int LEN_DATA    = 64,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter logic [LEN_DATA-1:0]            ERR_DATA   = DEF_ERR_DATA
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            master_ena,
    input  logic [NUM_MASTERS*LEN_ADDR-1:0]   master_addra,
    input  logic [NUM_MASTERS*LEN_DATA-1:0]   master_dina,
    input  logic [NUM_MASTERS*LEN_DATA/8-1:0] master_wea,
    output logic [NUM_MASTERS-1:0]            master_gnt,
    output logic [NUM_MASTERS-1:0]            master_rvalid,
    output logic [NUM_MASTERS*LEN_DATA-1:0]   master_douta,
    output logic [NUM_SLAVES-1:0]             slave_ena,
    output logic [NUM_SLAVES*LEN_ADDR-1:0]    slave_addra,
    output logic [NUM_SLAVES*LEN_DATA-1:0]    slave_dina,
    output logic [NUM_SLAVES*LEN_DATA/8-1:0]  slave_wea,
    input  logic [NUM_SLAVES*LEN_DATA-1:0]    slave_douta,
    output logic                              err_valid,
    output logic [LEN_ADDR-1:0]               err_addr,
    output logic [15:0]                       err_count
);

    localparam int BE_W   = LEN_DATA / 8;
    localparam int AIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [AIDX_W-1:0]   gnt_idx;
    logic                req_any;
    logic [LEN_ADDR-1:0] g_addr;
    logic [LEN_DATA-1:0] g_din;
    logic [BE_W-1:0]     g_we;
    logic                hit;
    logic [SIDX_W-1:0]   sidx;

    resp_t               resp_d, resp_q;
    logic [LEN_ADDR-1:0] err_addr_d, err_addr_q;
    logic [15:0]         err_count_d, err_count_q;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (master_ena),
        .gnt_o     (master_gnt),
        .gnt_idx_o (gnt_idx)
    );

    // Descending scan so the lowest-numbered matching slave wins overlaps.
    always_comb begin
        req_any = |master_ena;
        g_addr  = master_addra[int'(gnt_idx)*LEN_ADDR +: LEN_ADDR];
        g_din   = master_dina[int'(gnt_idx)*LEN_DATA +: LEN_DATA];
        g_we    = master_wea[int'(gnt_idx)*BE_W +: BE_W];
        hit     = 1'b0;
        sidx    = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            if ((g_addr & SLAVE_MASK[s*LEN_ADDR +: LEN_ADDR]) == SLAVE_BASE[s*LEN_ADDR +: LEN_ADDR]) begin
                hit  = 1'b1;
                sidx = SIDX_W'(s);
            end
        end
    end

    always_comb begin
        slave_ena   = '0;
        slave_addra = '0;
        slave_dina  = '0;
        slave_wea   = '0;
        if (req_any && hit) begin
            slave_ena[sidx]                              = 1'b1;
            slave_addra[int'(sidx)*LEN_ADDR +: LEN_ADDR] = g_addr;
            slave_dina[int'(sidx)*LEN_DATA +: LEN_DATA]  = g_din;
            slave_wea[int'(sidx)*BE_W +: BE_W]           = g_we;
        end
    end

    always_comb begin
        resp_d.valid    = req_any;
        resp_d.midx     = MIDX_W'(gnt_idx);
        resp_d.sidx     = sidx;
        resp_d.unmapped = !hit;
        err_addr_d      = err_addr_q;
        err_count_d     = err_count_q;
        if (req_any && !hit) begin
            err_addr_d = g_addr;
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q      <= '0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            resp_q      <= resp_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        master_rvalid = '0;
        master_douta  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (resp_q.valid && (resp_q.midx == MIDX_W'(m))) begin
                master_rvalid[m] = 1'b1;
                master_douta[m*LEN_DATA +: LEN_DATA] = resp_q.unmapped ? ERR_DATA :
                    slave_douta[int'(resp_q.sidx)*LEN_DATA +: LEN_DATA];
            end
        end
    end

    assign err_valid = resp_q.valid & resp_q.unmapped;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_mux
// Purpose  : Self-checking bench: directed table, reset/arbitration sequences,
//            randomized traffic against a reference model, overlap decode and
//            error-counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_mux;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam logic [63:0] ERR = 64'hDEADBEEF_DEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]    master_ena, master_gnt, master_rvalid;
    logic [NM*64-1:0] master_addra, master_dina, master_douta;
    logic [NM*8-1:0]  master_wea;
    logic [NS-1:0]    slave_ena;
    logic [NS*64-1:0] slave_addra, slave_dina, slave_douta;
    logic [NS*8-1:0]  slave_wea;
    logic             err_valid;
    logic [63:0]      err_addr;
    logic [15:0]      err_count;

    logic [NM-1:0]    o_ena, o_gnt, o_rvalid;
    logic [NM*64-1:0] o_addra, o_dina, o_douta;
    logic [NM*8-1:0]  o_wea;
    logic [NS-1:0]    o_sena;
    logic [NS*64-1:0] o_saddra, o_sdina, o_sdouta;
    logic [NS*8-1:0]  o_swea;
    logic             o_err_valid;
    logic [63:0]      o_err_addr;
    logic [15:0]      o_err_count;

    sram_bus_mux u_dut (
        .clk(clk), .rst(rst),
        .master_ena(master_ena), .master_addra(master_addra), .master_dina(master_dina),
        .master_wea(master_wea), .master_gnt(master_gnt), .master_rvalid(master_rvalid),
        .master_douta(master_douta), .slave_ena(slave_ena), .slave_addra(slave_addra),
        .slave_dina(slave_dina), .slave_wea(slave_wea), .slave_douta(slave_douta),
        .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
    );

    // Slaves 2 and 3 both cover the whole space; slaves 0/1 sit elsewhere.
    sram_bus_mux #(
        .SLAVE_BASE({64'h0, 64'h0, 64'h10000000, 64'h80000000}),
        .SLAVE_MASK({64'h0, 64'h0, ~64'hFFF, ~64'hFFFF})
    ) u_ovl (
        .clk(clk), .rst(rst),
        .master_ena(o_ena), .master_addra(o_addra), .master_dina(o_dina),
        .master_wea(o_wea), .master_gnt(o_gnt), .master_rvalid(o_rvalid),
        .master_douta(o_douta), .slave_ena(o_sena), .slave_addra(o_saddra),
        .slave_dina(o_sdina), .slave_wea(o_swea), .slave_douta(o_sdouta),
        .err_valid(o_err_valid), .err_addr(o_err_addr), .err_count(o_err_count)
    );

    int checks, errors;
    logic [63:0] ref_base [NS];
    logic [63:0] ref_mask [NS];
    logic [63:0] sd [NS];

    // Reference model state
    int          rr, pm, ps, last_gm;
    logic        pv, pu;
    logic [63:0] ea;
    logic [15:0] ec;

    typedef struct {
        int          m;
        logic [63:0] addr;
        logic [7:0]  we;
        logic [63:0] din;
        int          s;
    } vec_t;
    vec_t tbl [10];

    logic        rq_on [NM];
    logic [63:0] rq_addr [NM];
    logic [63:0] rq_din [NM];
    logic [7:0]  rq_we [NM];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [63:0] a);
        for (int s = 0; s < NS; s++)
            if ((a & ref_mask[s]) == ref_base[s]) return s;
        return -1;
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 64'($urandom_range(0, 65535));
            1:       return 64'h10000000 | 64'($urandom_range(0, 4095));
            2:       return 64'h60000000 | 64'($urandom_range(0, 7));
            3:       return 64'h80000000 | 64'($urandom_range(0, 65535));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic model_check();
        int gm, s;
        logic [63:0] ga, gd;
        logic [7:0]  gw;
        logic [NM-1:0] eg, erv;
        logic [NM*64-1:0] edo;
        logic [NS-1:0] esena;
        logic [NS*64-1:0] esa, esd;
        logic [NS*8-1:0] esw;
        gm = -1; s = -1; ga = '0; gd = '0; gw = '0;
        for (int i = 0; i < NM; i++)
            if (gm < 0 && master_ena[(rr + i) % NM]) gm = (rr + i) % NM;
        eg = '0; esena = '0; esa = '0; esd = '0; esw = '0;
        if (gm >= 0) begin
            eg[gm] = 1'b1;
            ga = master_addra[gm*64 +: 64];
            gd = master_dina[gm*64 +: 64];
            gw = master_wea[gm*8 +: 8];
            s  = decode(ga);
            if (s >= 0) begin
                esena[s] = 1'b1;
                esa[s*64 +: 64] = ga;
                esd[s*64 +: 64] = gd;
                esw[s*8 +: 8]   = gw;
            end
        end
        erv = '0; edo = '0;
        if (pv) begin
            erv[pm] = 1'b1;
            edo[pm*64 +: 64] = pu ? ERR : slave_douta[ps*64 +: 64];
        end
        chk("gnt", master_gnt, eg);
        chk("gnt_onehot", $countones(master_gnt) <= 1, 1);
        chk("slave_ena", slave_ena, esena);
        chk("slave_addra", slave_addra, esa);
        chk("slave_dina", slave_dina, esd);
        chk("slave_wea", slave_wea, esw);
        chk("rvalid", master_rvalid, erv);
        chk("douta", master_douta, edo);
        chk("err_valid", err_valid, pv && pu);
        chk("err_addr", err_addr, ea);
        chk("err_count", err_count, ec);
        last_gm = gm;
        if (rst) begin
            rr = 0; pv = 1'b0; ea = '0; ec = '0;
        end else if (gm >= 0) begin
            rr = (gm + 1) % NM;
            pv = 1'b1; pm = gm; ps = (s < 0) ? 0 : s; pu = (s < 0);
            if (pu) begin
                ea = ga;
                if (ec != 16'hFFFF) ec = ec + 16'd1;
            end
        end else begin
            pv = 1'b0;
        end
    endtask

    task automatic check_now();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_one(input int m, input logic [63:0] a, input logic [7:0] we, input logic [63:0] d);
        master_ena = '0; master_addra = '0; master_dina = '0; master_wea = '0;
        master_ena[m] = 1'b1;
        master_addra[m*64 +: 64] = a;
        master_dina[m*64 +: 64]  = d;
        master_wea[m*8 +: 8]     = we;
    endtask

    initial begin
        checks = 0; errors = 0;
        rr = 0; pm = 0; ps = 0; pv = 1'b0; pu = 1'b0; ea = '0; ec = '0; last_gm = -1;
        ref_base[0] = 64'h0;        ref_mask[0] = ~64'hFFFF;
        ref_base[1] = 64'h10000000; ref_mask[1] = ~64'hFFF;
        ref_base[2] = 64'h60000000; ref_mask[2] = ~64'h7;
        ref_base[3] = 64'h80000000; ref_mask[3] = ~64'hFFFF;
        sd[0] = 64'hA0A0A0A0_00000000; sd[1] = 64'hB1B1B1B1_11111111;
        sd[2] = 64'hC2C2C2C2_22222222; sd[3] = 64'h11223344_55667788;

        tbl[0] = '{0, 64'h80000010, 8'h00, 64'h0,  3};
        tbl[1] = '{1, 64'h60000000, 8'h01, 64'h41, 2};
        tbl[2] = '{0, 64'h20000000, 8'h00, 64'h0, -1};
        tbl[3] = '{1, 64'h10000FF8, 8'h00, 64'h0,  1};
        tbl[4] = '{0, 64'h00001234, 8'h00, 64'h0,  0};
        tbl[5] = '{0, 64'h60000008, 8'h00, 64'h0, -1};
        tbl[6] = '{1, 64'h8000FFFF, 8'h00, 64'h0,  3};
        tbl[7] = '{0, 64'h80010000, 8'h00, 64'h0, -1};
        tbl[8] = '{1, 64'h0000FFFF, 8'hFF, 64'h0123456789ABCDEF, 0};
        tbl[9] = '{0, 64'h10001000, 8'h0F, 64'h55, -1};

        rst = 1'b1;
        master_ena = '0; master_addra = '0; master_dina = '0; master_wea = '0;
        slave_douta = {sd[3], sd[2], sd[1], sd[0]};
        o_ena = '0; o_addra = '0; o_dina = '0; o_wea = '0;
        o_sdouta = {sd[3], sd[2], sd[1], sd[0]};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", master_rvalid, 0);
        chk("reset_err_valid", err_valid, 0);
        chk("reset_err_addr", err_addr, 0);
        chk("reset_err_count", err_count, 0);
        rst = 1'b0;

        // Directed decode table: request cycle, then response cycle
        for (int i = 0; i < 10; i++) begin
            drive_one(tbl[i].m, tbl[i].addr, tbl[i].we, tbl[i].din);
            check_now();
            chk("tbl_gnt", master_gnt, 1 << tbl[i].m);
            chk("tbl_sena", slave_ena, (tbl[i].s >= 0) ? (1 << tbl[i].s) : 0);
            advance();
            master_ena = '0;
            check_now();
            chk("tbl_rvalid", master_rvalid, 1 << tbl[i].m);
            chk("tbl_douta", master_douta[tbl[i].m*64 +: 64], (tbl[i].s < 0) ? ERR : sd[tbl[i].s]);
            chk("tbl_err_valid", err_valid, tbl[i].s < 0);
            advance();
        end

        // Reset in the cycle after an M0 grant, then both masters contend
        drive_one(0, 64'h00000100, 8'h00, 64'h0);
        check_now();
        advance();
        master_ena = '0;
        rst = 1'b1;
        check_now();
        advance();
        rst = 1'b0;
        master_ena = 2'b11;
        master_addra = {64'h10000010, 64'h80000020};
        check_now();
        chk("post_rst_rvalid", master_rvalid, 0);
        chk("post_rst_gnt", master_gnt, 2'b01);
        advance();
        for (int i = 1; i < 8; i++) begin
            check_now();
            chk("alt_gnt", master_gnt, (i % 2) ? 2'b10 : 2'b01);
            chk("alt_rvalid", master_rvalid, (i % 2) ? 2'b01 : 2'b10);
            advance();
        end

        // Randomized traffic; un-granted requests stay stable until granted
        for (int m = 0; m < NM; m++) rq_on[m] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++) begin
                if (!rq_on[m] && ($urandom_range(0, 9) < 6)) begin
                    rq_on[m]   = 1'b1;
                    rq_addr[m] = rand_addr();
                    rq_din[m]  = {$urandom, $urandom};
                    rq_we[m]   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                end
                master_ena[m]            = rq_on[m];
                master_addra[m*64 +: 64] = rq_addr[m];
                master_dina[m*64 +: 64]  = rq_din[m];
                master_wea[m*8 +: 8]     = rq_we[m];
            end
            slave_douta = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            check_now();
            if (last_gm >= 0) rq_on[last_gm] = 1'b0;
            advance();
        end
        master_ena = '0;
        check_now();
        advance();

        // Overlapping map on the second instance
        begin
            logic [63:0] oa [4];
            int          os [4];
            oa[0] = 64'h0;        os[0] = 2;
            oa[1] = 64'h80000004; os[1] = 0;
            oa[2] = 64'h12345678; os[2] = 2;
            oa[3] = 64'h10000ABC; os[3] = 1;
            for (int i = 0; i < 4; i++) begin
                o_ena = 2'b01;
                o_addra = {64'h0, oa[i]};
                #1;
                chk("ovl_sena", o_sena, 1 << os[i]);
                advance();
                o_ena = '0;
                #1;
                chk("ovl_rvalid", o_rvalid, 2'b01);
                chk("ovl_douta", o_douta[63:0], sd[os[i]]);
                advance();
            end
        end

        // Error counter saturation
        slave_douta = {sd[3], sd[2], sd[1], sd[0]};
        drive_one(0, 64'h20000000, 8'h00, 64'h0);
        for (int c = 0; c < 70000; c++) begin
            check_now();
            advance();
        end
        master_ena = '0;
        check_now();
        chk("sat_count", err_count, 16'hFFFF);
        chk("sat_addr", err_addr, 64'h20000000);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
